l2_arbiter: RTL
===============

L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ic_req_address  input  XLEN  icache L2 request address.
REQ-005 SHALL have port ic_req_type  input  memory_operation_e  icache request type (loads only expected).
REQ-006 SHALL have port ic_req_valid  input  1  icache request pending.
REQ-007 SHALL have port ic_fetched_word  output  XLEN  word returned to icache.
REQ-008 SHALL have port ic_req_fulfilled  output  1  one-cycle completion pulse to icache.
REQ-009 SHALL have ports dc_req_address, dc_req_type, dc_req_valid, dc_word_to_store (inputs) and dc_fetched_word, dc_req_fulfilled (outputs), with the same widths and meanings as the icache ports; dc_word_to_store is XLEN store data.
REQ-010 SHALL have ports l2_req_address (XLEN), l2_req_type (memory_operation_e), l2_req_valid (1), l2_word_to_store (XLEN) as outputs, and l2_fetched_word (XLEN), l2_req_fulfilled (1) as inputs, forming the single shared L2 port.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT_IC, GRANT_DC.
REQ-012 In IDLE, SHALL grant the single valid requester; if both are valid, SHALL grant the one not granted last (round-robin via a last_grant register, reset value = DC so IC wins first tie).
REQ-013 On grant, SHALL latch address, type and store data (zero for IC) into l2 request registers and enter GRANT_x in the next cycle.
REQ-014 SHALL assert l2_req_valid exactly in the GRANT states, driven from registers: request seen in IDLE at cycle N gives l2_req_valid at N+1.
REQ-015 Requester input changes after grant SHALL NOT alter l2_req_address/type/word_to_store until the next grant.
REQ-016 In GRANT_x, when l2_req_fulfilled=1, SHALL combinationally drive x_req_fulfilled=1 and x_fetched_word=l2_fetched_word in the same cycle, update last_grant=x, and return to IDLE.
REQ-017 A requester valid in the cycle after its fulfilled pulse SHALL be treated as a new request (multi-word line fills arbitrate per word).
REQ-018 If the granted requester drops valid before fulfillment, the L2 request SHALL remain asserted until l2_req_fulfilled, and that fulfilled pulse SHALL be absorbed (not forwarded).
REQ-019 The non-granted requester SHALL see fulfilled=0 and fetched_word=0 at all times.
REQ-020 l2_req_fulfilled in IDLE SHALL be ignored; no output changes.
REQ-021 Idle outputs: l2_req_valid=0, l2 address/data hold last latched value, both fulfilled outputs 0.

Reset
REQ-022 Reset SHALL force state=IDLE, last_grant=DC, l2_req_address=0, l2_req_type=LOAD encoding, l2_word_to_store=0, l2_req_valid=0, both fulfilled=0, both fetched_word=0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction; a coincident l2_req_fulfilled SHALL NOT be forwarded.

Structure
REQ-024 memory_operation_e SHALL come from xentry_pkg; the arbiter state enum and requester-id enum (REQ_IC, REQ_DC) SHALL be added to xentry_pkg.
REQ-025 Block SHALL be a single module; the round-robin pick SHALL be a small combinational function, no sub-module.

Verification
REQ-026 Reset, then IC valid addr 0x0000_1000 LOAD alone -> l2_req_valid at next cycle with addr 0x1000; L2 fulfilled with 0xDEAD_BEEF -> ic_req_fulfilled=1, ic_fetched_word=0xDEAD_BEEF same cycle.
REQ-027 IC 0x100 and DC 0x200 valid same cycle after reset -> IC served first, DC second; repeat tie -> DC first (alternation).
REQ-028 DC STORE addr 0x0000_0040 data 0x1234_5678, DC changes inputs to 0x80 while granted -> L2 sees 0x40/0x1234_5678 until fulfilled.
REQ-029 DC granted, dc_req_valid drops, L2 fulfills 3 cycles later -> dc_req_fulfilled stays 0, FSM returns to IDLE.
REQ-030 Reset pulsed while GRANT_IC with l2_req_fulfilled=1 same cycle -> ic_req_fulfilled=0, l2_req_valid=0 next cycle; stray l2_req_fulfilled in IDLE -> no output change.

Source files
------------

// File: rtl/xentry_pkg.sv
// Shared memory-system types: operation encoding plus the L2 arbiter's state
// and requester-id enums.
package xentry_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IC = 2'd1,
        GRANT_DC = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

endpackage

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between icache and dcache; one
// word per grant, with request fields latched at grant time.
module l2_arbiter
    import xentry_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [XLEN-1:0]   ic_req_address,
    input  memory_operation_e ic_req_type,
    input  logic              ic_req_valid,
    output logic [XLEN-1:0]   ic_fetched_word,
    output logic              ic_req_fulfilled,

    input  logic [XLEN-1:0]   dc_req_address,
    input  memory_operation_e dc_req_type,
    input  logic              dc_req_valid,
    input  logic [XLEN-1:0]   dc_word_to_store,
    output logic [XLEN-1:0]   dc_fetched_word,
    output logic              dc_req_fulfilled,

    output logic [XLEN-1:0]   l2_req_address,
    output memory_operation_e l2_req_type,
    output logic              l2_req_valid,
    output logic [XLEN-1:0]   l2_word_to_store,
    input  logic [XLEN-1:0]   l2_fetched_word,
    input  logic              l2_req_fulfilled
);

    // On a tie, the requester that did not win last time gets the port.
    function automatic req_id_e rr_pick(logic ic_v, logic dc_v, req_id_e last);
        if (ic_v && dc_v) return (last == REQ_DC) ? REQ_IC : REQ_DC;
        return ic_v ? REQ_IC : REQ_DC;
    endfunction

    arb_state_e        state_q, state_d;
    req_id_e           last_q, last_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    memory_operation_e type_q, type_d;
    logic [XLEN-1:0]   wts_q, wts_d;
    logic              valid_q, valid_d;
    logic              drop_q, drop_d;

    req_id_e           pick;
    logic              granted_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= REQ_DC;
            addr_q  <= '0;
            type_q  <= LOAD;
            wts_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            wts_q   <= wts_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        type_d  = type_q;
        wts_d   = wts_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        pick    = rr_pick(ic_req_valid, dc_req_valid, last_q);
        granted_valid = (state_q == GRANT_IC) ? ic_req_valid : dc_req_valid;
        case (state_q)
            IDLE: begin
                if (ic_req_valid || dc_req_valid) begin
                    valid_d = 1'b1;
                    drop_d  = 1'b0;
                    if (pick == REQ_IC) begin
                        state_d = GRANT_IC;
                        addr_d  = ic_req_address;
                        type_d  = ic_req_type;
                        wts_d   = '0;
                    end else begin
                        state_d = GRANT_DC;
                        addr_d  = dc_req_address;
                        type_d  = dc_req_type;
                        wts_d   = dc_word_to_store;
                    end
                end
            end
            GRANT_IC, GRANT_DC: begin
                // A requester that withdrew keeps the L2 access alive but loses the reply.
                if (!granted_valid) drop_d = 1'b1;
                if (l2_req_fulfilled) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = (state_q == GRANT_IC) ? REQ_IC : REQ_DC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ic_req_fulfilled = 1'b0;
        dc_req_fulfilled = 1'b0;
        ic_fetched_word  = '0;
        dc_fetched_word  = '0;
        if (!reset && l2_req_fulfilled && !drop_q) begin
            if (state_q == GRANT_IC && ic_req_valid) begin
                ic_req_fulfilled = 1'b1;
                ic_fetched_word  = l2_fetched_word;
            end
            if (state_q == GRANT_DC && dc_req_valid) begin
                dc_req_fulfilled = 1'b1;
                dc_fetched_word  = l2_fetched_word;
            end
        end
    end

    assign l2_req_address   = addr_q;
    assign l2_req_type      = type_q;
    assign l2_word_to_store = wts_q;
    assign l2_req_valid     = valid_q;

endmodule
